aes_dec_round_ctrl: RTL and testbench

Sequencing controller for AES-128 decryption. It accepts a ciphertext/key pair over a valid/ready handshake and drives the external `keygen` expansion step to build and cache the 11 round keys. It then steps an external combinational inverse-round datapath through rounds 9..0 and returns the plaintext over a valid/ready handshake. It sits between the Pass-Keeper storage front end and the decryption datapath.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_dec_round_ctrl_if.sv | 23 ++
 rtl/aes_round_key_store.sv | 30 +++
 rtl/aes_dec_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 decryption round controller.
package aes_pkg;

    localparam int AES_NR  = 10;
    localparam int AES_BW  = 128;
    localparam int KEY_CNT = AES_NR + 1;

    typedef logic [AES_BW-1:0] block_t;
    typedef logic [3:0]        key_idx_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXPAND = 3'd1,
        ADDKEY = 3'd2,
        ROUND  = 3'd3,
        OUT    = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// Job handshake between the storage front end (master) and the decryption controller (slave).
interface aes_dec_round_ctrl_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    block_t in_key;
    block_t in_data;
    logic   out_valid;
    logic   out_ready;
    block_t out_data;

    modport master (
        output in_valid, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_round_key_store.sv
// 11-entry round key cache: one write port, one read port, plus dedicated taps on keys[0] and keys[10].
module aes_round_key_store
    import aes_pkg::*;
(
    input  logic     clk,
    input  logic     we,
    input  key_idx_t wr_idx,
    input  block_t   wr_data,
    input  key_idx_t rd_idx,
    output block_t   rd_data,
    output block_t   key_first,
    output block_t   key_last
);

    localparam key_idx_t LAST_IDX = 4'(AES_NR);

    // Contents need no reset: the controller ignores them until key_valid is set.
    block_t keys [KEY_CNT];

    always_ff @(posedge clk) begin
        if (we && (wr_idx <= LAST_IDX)) begin
            keys[wr_idx] <= wr_data;
        end
    end

    assign rd_data   = (rd_idx <= LAST_IDX) ? keys[rd_idx] : '0;
    assign key_first = keys[0];
    assign key_last  = keys[AES_NR];

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// AES-128 decryption sequencer: caches the expanded key schedule and steps an external
// inverse-round datapath from round 9 down to round 0.
//
//   state  | meaning
//   IDLE   | waiting for a ciphertext/key job, in_ready high
//   EXPAND | building keys[1..10] through keygen, one per cycle
//   ADDKEY | initial AddRoundKey with keys[10]
//   ROUND  | one inverse round per cycle, rnd 9..0
//   OUT    | plaintext presented until out_ready
module aes_dec_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int BW = AES_BW
) (
    input  logic                 clk,
    input  logic                 rest,
    aes_dec_round_ctrl_if.slave  bus,
    output logic                 busy,
    output logic [3:0]           kg_round,
    output logic [BW-1:0]        kg_prev_key,
    input  logic [BW-1:0]        kg_key_out,
    output logic [BW-1:0]        rd_state,
    output logic [BW-1:0]        rd_key,
    output logic                 rd_last,
    input  logic [BW-1:0]        rd_result
);

    localparam key_idx_t LAST_IDX  = 4'(NR);
    localparam key_idx_t FIRST_RND = 4'(NR - 1);

    ctrl_state_e   state_q, state_nxt;
    key_idx_t      cnt_q;
    key_idx_t      rnd_q;
    logic          key_valid_q;
    logic [BW-1:0] data_reg;
    logic [BW-1:0] state_reg;

    logic          key_we;
    key_idx_t      key_wr_idx;
    logic [BW-1:0] key_wr_data;
    key_idx_t      key_rd_idx;
    logic [BW-1:0] key_rd_data;
    logic [BW-1:0] key_first;
    logic [BW-1:0] key_last;
    logic          key_hit;

    aes_round_key_store u_key_store (
        .clk       (clk),
        .we        (key_we),
        .wr_idx    (key_wr_idx),
        .wr_data   (key_wr_data),
        .rd_idx    (key_rd_idx),
        .rd_data   (key_rd_data),
        .key_first (key_first),
        .key_last  (key_last)
    );

    assign key_hit = key_valid_q && (bus.in_key == key_first);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        key_we        = 1'b0;
        key_wr_idx    = '0;
        key_wr_data   = kg_key_out;
        key_rd_idx    = '0;
        kg_round      = '0;
        kg_prev_key   = '0;
        rd_state      = '0;
        rd_key        = '0;
        rd_last       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    key_we      = 1'b1;
                    key_wr_idx  = '0;
                    key_wr_data = bus.in_key;
                    state_nxt   = key_hit ? ADDKEY : EXPAND;
                end
            end
            EXPAND: begin
                kg_round    = cnt_q;
                key_rd_idx  = cnt_q - 4'd1;
                kg_prev_key = key_rd_data;
                key_we      = 1'b1;
                key_wr_idx  = cnt_q;
                key_wr_data = kg_key_out;
                if (cnt_q == LAST_IDX) begin
                    state_nxt = ADDKEY;
                end
            end
            ADDKEY: begin
                state_nxt = ROUND;
            end
            ROUND: begin
                key_rd_idx = rnd_q;
                rd_state   = state_reg;
                rd_key     = key_rd_data;
                rd_last    = (rnd_q == 4'd0);
                if (rnd_q == 4'd0) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = state_reg;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A miss drops key_valid at accept so an abandoned expansion never leaves a stale hit behind.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt_q       <= '0;
            rnd_q       <= '0;
            key_valid_q <= 1'b0;
            data_reg    <= '0;
            state_reg   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_reg <= bus.in_data;
                        if (!key_hit) begin
                            key_valid_q <= 1'b0;
                            cnt_q       <= 4'd1;
                        end
                    end
                end
                EXPAND: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        key_valid_q <= 1'b1;
                    end
                end
                ADDKEY: begin
                    state_reg <= data_reg ^ key_last;
                    rnd_q     <= FIRST_RND;
                end
                ROUND: begin
                    state_reg <= rd_result;
                    if (rnd_q != 4'd0) begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Scoreboard bench for aes_dec_round_ctrl with behavioural keygen and inverse-round models.
module tb_aes_dec_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk  = 1'b0;
    logic rest = 1'b1;
    always #5 clk = ~clk;

    aes_dec_round_ctrl_if bus ();

    logic         busy;
    logic [3:0]   kg_round;
    logic [127:0] kg_prev_key, kg_key_out;
    logic [127:0] rd_state, rd_key, rd_result;
    logic         rd_last;

    aes_dec_round_ctrl dut (
        .clk         (clk),
        .rest        (rest),
        .bus         (bus),
        .busy        (busy),
        .kg_round    (kg_round),
        .kg_prev_key (kg_prev_key),
        .kg_key_out  (kg_key_out),
        .rd_state    (rd_state),
        .rd_key      (rd_key),
        .rd_last     (rd_last),
        .rd_result   (rd_result)
    );

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] res, p;
        res = 8'h01; p = a;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            res = gmul(res, p);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] keygen(input logic [127:0] prev, input logic [3:0] rnd);
        logic [31:0] w3, rot, sub, t, n0, n1, n2, n3;
        logic [7:0]  rc;
        w3  = prev[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        rc  = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
        t  = sub ^ {rc, 24'h0};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64] ^ n0;
        n2 = prev[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t, r;
        logic [7:0]   a0, a1, a2, a3;
        t = '0; r = '0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[127-8*(4*c+rr) -: 8] = inv_sbox(s[127-8*(4*((c-rr+4)%4)+rr) -: 8]);
        t = t ^ k;
        if (last) return t;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            r[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            r[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            r[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return r;
    endfunction

    always_comb kg_key_out = keygen(kg_prev_key, kg_round);
    always_comb rd_result  = inv_round(rd_state, rd_key, rd_last);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] pt;
        logic [127:0] key0;
        logic [127:0] k10;
        int           lat;
        int           kg_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    exp_t mon_e;
    int   mon_acc;
    int   kg_cnt = 0;
    int   last_cnt = 0;
    logic prev_ov = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rest) begin
                acc_q.delete();
                kg_cnt   = 0;
                last_cnt = 0;
                prev_ov  = 1'b0;
            end else begin
                if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
                if (kg_round != 4'd0) kg_cnt++;
                if (rd_last) begin
                    last_cnt++;
                    if (exp_q.size() > 0) check("rd_key_at_last", rd_key, exp_q[0].key0);
                end
                if (bus.out_valid && !prev_ov) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: got out_data %h with no job pending",
                                 bus.out_data);
                    end else begin
                        mon_e   = exp_q.pop_front();
                        mon_acc = acc_q.pop_front();
                        check("out_data", bus.out_data, mon_e.pt);
                        check("latency", 128'(cyc - mon_acc), 128'(mon_e.lat));
                        check("kg_active_cycles", 128'(kg_cnt), 128'(mon_e.kg_cycles));
                        check("rd_last_count", 128'(last_cnt), 128'(1));
                        check("keys10", dut.u_key_store.key_last, mon_e.k10);
                    end
                    kg_cnt   = 0;
                    last_cnt = 0;
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs();
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_data", bus.out_data, 128'(0));
        check("rst_kg_round", 128'(kg_round), 128'(0));
        check("rst_kg_prev_key", kg_prev_key, 128'(0));
        check("rst_rd_state", rd_state, 128'(0));
        check("rst_rd_key", rd_key, 128'(0));
        check("rst_rd_last", 128'(rd_last), 128'(0));
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got no out_valid within 40 cycles, expected one");
        end
    endtask

    task automatic run_job(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                           input logic [127:0] k10, input bit hit, input int hold);
        exp_t e;
        bit   ok;
        e.pt = pt; e.key0 = key; e.k10 = k10;
        e.lat = hit ? 11 : 21;
        e.kg_cycles = hit ? 0 : 10;
        exp_q.push_back(e);
        bus.in_key    = key;
        bus.in_data   = ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(ok);
        if (ok && hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                bus.in_valid = ((i % 2) == 0);
                bus.in_data  = ~ct;
                bus.in_key   = ~key;
                @(negedge clk);
                check("bp_out_valid", 128'(bus.out_valid), 128'(1));
                check("bp_out_data", bus.out_data, pt);
                check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            end
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            check("bp_idle_in_ready", 128'(bus.in_ready), 128'(1));
            check("bp_out_valid_drop", 128'(bus.out_valid), 128'(0));
        end else begin
            @(posedge clk); #1;
        end
    endtask

    // Hit job aborted by reset in the ROUND cycle with rnd==4.
    task automatic run_abort(input logic [127:0] key, input logic [127:0] ct);
        bus.in_key    = key;
        bus.in_data   = ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_busy", 128'(busy), 128'(1));
        check("abort_at_rnd4", 128'(dut.rnd_q), 128'(4));
        rest = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rest = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_key    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2 rest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rest = 1'b1;
        @(posedge clk); #1;

        run_job(K1, CT1, PT1, K1_10, 1'b0, 0);
        run_job(K1, CT1, PT1, K1_10, 1'b1, 0);
        run_job(K2, CT2, PT2, K2_10, 1'b0, 0);
        run_job(K2, CT2, PT2, K2_10, 1'b1, 5);
        run_abort(K2, CT2);
        run_job(K2, CT2, PT2, K2_10, 1'b0, 0);
        run_job(K1, CT1, PT1, K1_10, 1'b0, 0);
        run_job(K1, CT1, PT1, K1_10, 1'b1, 0);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
